// File: rtl/fmps_test_pkg.sv
// Shared definitions for the FMPS test-link checker: default field values,
// header/data bit positions, receive states and error flag indices.
package fmps_test_pkg;

  localparam logic [15:0] DEF_HEADER_MAGIC = 16'hB6CF;
  localparam logic [15:0] DEF_DATA_PATTERN = 16'hCACA;

  localparam int IDX_W         = 5;
  localparam int FA_W          = 8;
  localparam int MAGIC_W       = 16;
  localparam int PAT_W         = 16;
  localparam int HDR_MAGIC_LSB = 16;
  localparam int HDR_EN_BIT    = 15;
  localparam int HDR_IDX_LSB   = 10;
  localparam int HDR_RSV_W     = 10;
  localparam int DAT_RSV_LSB   = 29;
  localparam int DAT_RSV_W     = 3;
  localparam int DAT_IDX_LSB   = 24;
  localparam int DAT_PAT_LSB   = 8;
  localparam int DAT_FA_LSB    = 0;

  localparam int ERR_W       = 5;
  localparam int ERR_MAGIC   = 0;
  localparam int ERR_INDEX   = 1;
  localparam int ERR_PATTERN = 2;
  localparam int ERR_FRAMING = 3;
  localparam int ERR_SEQ     = 4;

  typedef enum logic [1:0] {
    ST_HDR  = 2'd0,
    ST_DAT  = 2'd1,
    ST_DROP = 2'd2
  } rx_state_t;

endpackage

// File: rtl/fmps_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module fmps_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && !(&r_count)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/fmps_test_link_checker.sv
// Checks 2-word FMPS test packets (header + data/tlast) and keeps counters and
// sticky error flags. Define FMPS_CHECK_SEQ_EN to build the sequence check.
//
// state | meaning
// HDR   | waiting for a header beat
// DAT   | header taken, waiting for the data beat carrying tlast
// DROP  | framing lost, discarding beats up to the next tlast
module fmps_test_link_checker
  import fmps_test_pkg::*;
#(
  parameter logic [15:0] HEADER_MAGIC = DEF_HEADER_MAGIC,
  parameter logic [15:0] DATA_PATTERN = DEF_DATA_PATTERN,
  parameter int          CNT_WIDTH    = 16
) (
  input  logic                 auroraUserClk,
  input  logic                 auroraUserResetN,
  input  logic                 auroraFAstrobe,
  input  logic                 clearCounters,
  input  logic [31:0]          s_tdata,
  input  logic                 s_tvalid,
  input  logic                 s_tlast,
  output logic                 s_tready,
  output logic                 packetStrobe,
  output logic [IDX_W-1:0]     lastIndex,
  output logic [FA_W-1:0]      lastFAcycle,
  output logic [CNT_WIDTH-1:0] packetCount,
  output logic [CNT_WIDTH-1:0] errorCount,
  output logic [ERR_W-1:0]     errorFlags
);

  localparam logic [ERR_W-1:0] FRAMING_MASK = ERR_W'(1) << ERR_FRAMING;

  rx_state_t r_state, w_state_nxt;

  logic             r_ready;
  logic             w_accept;
  logic             w_hdr_take;
  logic             w_eval;
  logic             w_frame_err;
  logic             r_hdr_magic_bad;
  logic             r_hdr_en_bad;
  logic             r_hdr_rsv_bad;
  logic [IDX_W-1:0] r_hdr_idx;
  logic [IDX_W-1:0] w_dat_idx;
  logic [FA_W-1:0]  w_dat_fa;
  logic [ERR_W-1:0] w_flags_chk;
  logic [ERR_W-1:0] w_flags_new;
  logic             w_seq_bad;
  logic             w_pkt_good;
  logic             w_pkt_bad;
  logic             r_strobe;
  logic [IDX_W-1:0] r_last_idx;
  logic [FA_W-1:0]  r_last_fa;
  logic [ERR_W-1:0] r_err_flags;

  assign w_accept = s_tvalid && r_ready;

  always_ff @(posedge auroraUserClk or negedge auroraUserResetN) begin
    if (!auroraUserResetN) begin
      r_state <= ST_HDR;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ready <= 1'b1;
    end
  end

  // A strobe cycle overrides everything, including a beat accepted alongside it.
  always_comb begin
    w_state_nxt = r_state;
    w_hdr_take  = 1'b0;
    w_eval      = 1'b0;
    w_frame_err = 1'b0;
    if (auroraFAstrobe) begin
      w_state_nxt = ST_HDR;
    end else if (w_accept) begin
      case (r_state)
        ST_HDR: begin
          if (s_tlast) begin
            w_frame_err = 1'b1;
          end else begin
            w_hdr_take  = 1'b1;
            w_state_nxt = ST_DAT;
          end
        end
        ST_DAT: begin
          if (!s_tlast) begin
            w_frame_err = 1'b1;
            w_state_nxt = ST_DROP;
          end else begin
            w_eval      = 1'b1;
            w_state_nxt = ST_HDR;
          end
        end
        ST_DROP: begin
          if (s_tlast) w_state_nxt = ST_HDR;
        end
        default: w_state_nxt = ST_HDR;
      endcase
    end
  end

  always_ff @(posedge auroraUserClk or negedge auroraUserResetN) begin
    if (!auroraUserResetN) begin
      r_hdr_magic_bad <= 1'b0;
      r_hdr_en_bad    <= 1'b0;
      r_hdr_rsv_bad   <= 1'b0;
      r_hdr_idx       <= '0;
    end else if (w_hdr_take) begin
      r_hdr_magic_bad <= s_tdata[HDR_MAGIC_LSB +: MAGIC_W] != HEADER_MAGIC;
      r_hdr_en_bad    <= !s_tdata[HDR_EN_BIT];
      r_hdr_rsv_bad   <= s_tdata[HDR_RSV_W-1:0] != '0;
      r_hdr_idx       <= s_tdata[HDR_IDX_LSB +: IDX_W];
    end
  end

  assign w_dat_idx = s_tdata[DAT_IDX_LSB +: IDX_W];
  assign w_dat_fa  = s_tdata[DAT_FA_LSB +: FA_W];

`ifdef FMPS_CHECK_SEQ_EN
  logic r_sess_first;
  logic r_hdr_first;
  logic r_exempt;

  // lastFAcycle doubles as the session FA cycle: every good packet in a session carries it.
  always_ff @(posedge auroraUserClk or negedge auroraUserResetN) begin
    if (!auroraUserResetN) begin
      r_sess_first <= 1'b0;
      r_hdr_first  <= 1'b0;
      r_exempt     <= 1'b1;
    end else begin
      if (auroraFAstrobe)  r_sess_first <= 1'b1;
      else if (w_hdr_take) r_sess_first <= 1'b0;
      if (w_hdr_take) r_hdr_first <= r_sess_first;
      if (clearCounters) r_exempt <= 1'b1;
      else if (w_eval)   r_exempt <= 1'b0;
    end
  end

  always_comb begin
    w_seq_bad = 1'b0;
    if (!r_exempt) begin
      if (r_hdr_first) w_seq_bad = w_dat_fa != (r_last_fa + 8'd1);
      else             w_seq_bad = (w_dat_idx != (r_last_idx + 5'd1)) || (w_dat_fa != r_last_fa);
    end
  end
`else
  assign w_seq_bad = 1'b0;
`endif

  always_comb begin
    w_flags_chk              = '0;
    w_flags_chk[ERR_MAGIC]   = r_hdr_magic_bad;
    w_flags_chk[ERR_INDEX]   = r_hdr_en_bad || (w_dat_idx != r_hdr_idx);
    w_flags_chk[ERR_PATTERN] = r_hdr_rsv_bad
                            || (s_tdata[DAT_PAT_LSB +: PAT_W] != DATA_PATTERN)
                            || (s_tdata[DAT_RSV_LSB +: DAT_RSV_W] != '0);
    w_flags_chk[ERR_SEQ]     = w_seq_bad;
  end

  assign w_pkt_good  = w_eval && (w_flags_chk == '0);
  assign w_pkt_bad   = w_frame_err || (w_eval && (w_flags_chk != '0));
  assign w_flags_new = w_frame_err ? FRAMING_MASK : w_flags_chk;

  always_ff @(posedge auroraUserClk or negedge auroraUserResetN) begin
    if (!auroraUserResetN) begin
      r_strobe    <= 1'b0;
      r_last_idx  <= '0;
      r_last_fa   <= '0;
      r_err_flags <= '0;
    end else if (clearCounters) begin
      r_strobe    <= 1'b0;
      r_last_idx  <= '0;
      r_last_fa   <= '0;
      r_err_flags <= '0;
    end else begin
      r_strobe <= w_pkt_good;
      if (w_pkt_good) begin
        r_last_idx <= w_dat_idx;
        r_last_fa  <= w_dat_fa;
      end
      if (w_pkt_bad) r_err_flags <= r_err_flags | w_flags_new;
    end
  end

  fmps_sat_counter #(.WIDTH(CNT_WIDTH)) u_pkt_cnt (
    .clk     (auroraUserClk),
    .rst_n   (auroraUserResetN),
    .i_inc   (w_pkt_good),
    .i_clr   (clearCounters),
    .o_count (packetCount)
  );

  fmps_sat_counter #(.WIDTH(CNT_WIDTH)) u_err_cnt (
    .clk     (auroraUserClk),
    .rst_n   (auroraUserResetN),
    .i_inc   (w_pkt_bad),
    .i_clr   (clearCounters),
    .o_count (errorCount)
  );

  assign s_tready     = r_ready;
  assign packetStrobe = r_strobe;
  assign lastIndex    = r_last_idx;
  assign lastFAcycle  = r_last_fa;
  assign errorFlags   = r_err_flags;

endmodule

// File: tb/tb_fmps_test_link_checker.sv
// Directed bench for fmps_test_link_checker; a second 4-bit-counter instance
// exercises counter saturation.
module tb_fmps_test_link_checker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fa_strobe = 1'b0;
  logic        clr = 1'b0;
  logic [31:0] tdata = '0;
  logic        tvalid = 1'b0;
  logic        tlast = 1'b0;
  logic        sel_small = 1'b0;

  logic        tready, pstrobe;
  logic [4:0]  last_idx, err_flags;
  logic [7:0]  last_fa;
  logic [15:0] pkt_cnt, err_cnt;

  logic        tready_s, pstrobe_s;
  logic [4:0]  last_idx_s, err_flags_s;
  logic [7:0]  last_fa_s;
  logic [3:0]  pkt_cnt_s, err_cnt_s;

  int n_checks = 0;
  int n_fail = 0;
  int strobe_cnt = 0;

  always #5 clk = ~clk;

  fmps_test_link_checker dut (
    .auroraUserClk(clk), .auroraUserResetN(rst_n), .auroraFAstrobe(fa_strobe),
    .clearCounters(clr), .s_tdata(tdata), .s_tvalid(tvalid && !sel_small), .s_tlast(tlast),
    .s_tready(tready), .packetStrobe(pstrobe), .lastIndex(last_idx), .lastFAcycle(last_fa),
    .packetCount(pkt_cnt), .errorCount(err_cnt), .errorFlags(err_flags)
  );

  fmps_test_link_checker #(.CNT_WIDTH(4)) dut_s (
    .auroraUserClk(clk), .auroraUserResetN(rst_n), .auroraFAstrobe(fa_strobe),
    .clearCounters(clr), .s_tdata(tdata), .s_tvalid(tvalid && sel_small), .s_tlast(tlast),
    .s_tready(tready_s), .packetStrobe(pstrobe_s), .lastIndex(last_idx_s), .lastFAcycle(last_fa_s),
    .packetCount(pkt_cnt_s), .errorCount(err_cnt_s), .errorFlags(err_flags_s)
  );

  always @(negedge clk) if (pstrobe) strobe_cnt++;

  function automatic logic [31:0] hdr_word(input logic [4:0] idx);
    return {16'hB6CF, 1'b1, idx, 10'd0};
  endfunction

  function automatic logic [31:0] dat_word(input logic [4:0] idx, input logic [7:0] fa);
    return {3'b000, idx, 16'hCACA, fa};
  endfunction

  task automatic send(input logic [31:0] d, input logic last);
    tdata = d; tlast = last; tvalid = 1'b1;
    @(posedge clk); #1;
    tvalid = 1'b0; tlast = 1'b0;
  endtask

  task automatic send_pkt(input logic [4:0] idx, input logic [7:0] fa);
    send(hdr_word(idx), 1'b0);
    send(dat_word(idx, fa), 1'b1);
  endtask

  task automatic pulse_fa();
    fa_strobe = 1'b1; @(posedge clk); #1; fa_strobe = 1'b0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1; @(posedge clk); #1; clr = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; tvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if (tready !== 1'b0) begin
      n_fail++; $display("FAIL reset_tready: got %b want 0", tready);
    end
    n_checks++;
    if ({pstrobe, last_idx, last_fa, pkt_cnt, err_cnt, err_flags} !== 51'd0) begin
      n_fail++; $display("FAIL reset_outputs: got %h want 0", {pstrobe, last_idx, last_fa, pkt_cnt, err_cnt, err_flags});
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (tready !== 1'b1) begin
      n_fail++; $display("FAIL ready_after_reset: got %b want 1", tready);
    end
  endtask

  task automatic test_good_packets();
    logic [7:0] fa;
    strobe_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      fa = 8'h05 + 8'(i);
      pulse_fa();
      send(32'hB6CF8400, 1'b0);
      send({8'h01, 16'hCACA, fa}, 1'b1);
      n_checks++;
      if (pstrobe !== 1'b1) begin
        n_fail++; $display("FAIL good_strobe_%0d: got %b want 1", i, pstrobe);
      end
    end
    @(posedge clk); #1;
    n_checks++;
    if (pkt_cnt !== 16'd3 || err_cnt !== 16'd0) begin
      n_fail++; $display("FAIL good_counts: got pkt=%0d err=%0d want pkt=3 err=0", pkt_cnt, err_cnt);
    end
    n_checks++;
    if (last_idx !== 5'd1 || last_fa !== 8'h07) begin
      n_fail++; $display("FAIL good_last: got idx=%0d fa=%h want idx=1 fa=07", last_idx, last_fa);
    end
    n_checks++;
    if (strobe_cnt != 3 || err_flags !== 5'd0) begin
      n_fail++; $display("FAIL good_pulses: got pulses=%0d flags=%b want 3 00000", strobe_cnt, err_flags);
    end
  endtask

  task automatic test_bad_magic();
    pulse_clr();
    send(32'hB6CE8400, 1'b0);
    send(32'h01CACA05, 1'b1);
    n_checks++;
    if (err_cnt !== 16'd1 || err_flags !== 5'b00001 || pkt_cnt !== 16'd0) begin
      n_fail++; $display("FAIL bad_magic: got err=%0d flags=%b pkt=%0d want 1 00001 0", err_cnt, err_flags, pkt_cnt);
    end
  endtask

  task automatic test_bad_fields();
    pulse_clr();
    send({16'hB6CF, 1'b0, 5'd1, 10'd0}, 1'b0);
    send(dat_word(5'd2, 8'h05), 1'b1);
    send({16'hB6CF, 1'b1, 5'd1, 10'd4}, 1'b0);
    send({3'b001, 5'd1, 16'hCACB, 8'h05}, 1'b1);
    n_checks++;
    if (err_cnt !== 16'd2 || err_flags !== 5'b00110 || pkt_cnt !== 16'd0) begin
      n_fail++; $display("FAIL bad_fields: got err=%0d flags=%b pkt=%0d want 2 00110 0", err_cnt, err_flags, pkt_cnt);
    end
  endtask

  task automatic test_header_tlast();
    pulse_clr();
    send(hdr_word(5'd1), 1'b1);
    send_pkt(5'd1, 8'h05);
    n_checks++;
    if (err_cnt !== 16'd1 || err_flags !== 5'b01000 || pkt_cnt !== 16'd1) begin
      n_fail++; $display("FAIL hdr_tlast: got err=%0d flags=%b pkt=%0d want 1 01000 1", err_cnt, err_flags, pkt_cnt);
    end
  endtask

  task automatic test_drop_resync();
    pulse_clr();
    send(hdr_word(5'd1), 1'b0);
    send(dat_word(5'd1, 8'h05), 1'b0);
    send(32'hDEADBEEF, 1'b0);
    send(32'h12345678, 1'b0);
    send(32'hB6CF8400, 1'b1);
    n_checks++;
    if (err_cnt !== 16'd1 || pkt_cnt !== 16'd0 || err_flags !== 5'b01000) begin
      n_fail++; $display("FAIL drop_once: got err=%0d pkt=%0d flags=%b want 1 0 01000", err_cnt, pkt_cnt, err_flags);
    end
    send_pkt(5'd1, 8'h09);
    n_checks++;
    if (err_cnt !== 16'd1 || pkt_cnt !== 16'd1 || last_fa !== 8'h09) begin
      n_fail++; $display("FAIL drop_resync: got err=%0d pkt=%0d fa=%h want 1 1 09", err_cnt, pkt_cnt, last_fa);
    end
  endtask

  task automatic test_fa_midpacket();
    pulse_clr();
    send_pkt(5'd1, 8'h10);
    send(hdr_word(5'd1), 1'b0);
    tdata = hdr_word(5'd1); tvalid = 1'b1;
    pulse_fa();
    tvalid = 1'b0;
    n_checks++;
    if (pkt_cnt !== 16'd1 || err_cnt !== 16'd0) begin
      n_fail++; $display("FAIL fa_drop: got pkt=%0d err=%0d want 1 0", pkt_cnt, err_cnt);
    end
    send_pkt(5'd1, 8'h11);
    n_checks++;
    if (pkt_cnt !== 16'd2 || err_cnt !== 16'd0 || last_fa !== 8'h11) begin
      n_fail++; $display("FAIL fa_next: got pkt=%0d err=%0d fa=%h want 2 0 11", pkt_cnt, err_cnt, last_fa);
    end
  endtask

  task automatic test_clear_in_eval();
    pulse_clr();
    send_pkt(5'd3, 8'h40);
    send(32'hB6CE8400, 1'b0);
    send(32'h01CACA05, 1'b1);
    send(hdr_word(5'd1), 1'b0);
    clr = 1'b1;
    send(dat_word(5'd1, 8'h05), 1'b1);
    clr = 1'b0;
    n_checks++;
    if ({pstrobe, last_idx, last_fa, pkt_cnt, err_cnt, err_flags} !== 51'd0) begin
      n_fail++; $display("FAIL clear_eval: got %h want 0", {pstrobe, last_idx, last_fa, pkt_cnt, err_cnt, err_flags});
    end
  endtask

  task automatic test_reset_midpacket();
    send_pkt(5'd1, 8'h05);
    send(hdr_word(5'd1), 1'b0);
    apply_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (pkt_cnt !== 16'd0 || last_fa !== 8'h00) begin
      n_fail++; $display("FAIL reset_mid: got pkt=%0d fa=%h want 0 00", pkt_cnt, last_fa);
    end
    send_pkt(5'd2, 8'h33);
    n_checks++;
    if (pkt_cnt !== 16'd1 || err_cnt !== 16'd0 || last_idx !== 5'd2) begin
      n_fail++; $display("FAIL reset_mid_pkt: got pkt=%0d err=%0d idx=%0d want 1 0 2", pkt_cnt, err_cnt, last_idx);
    end
  endtask

  task automatic test_saturation();
    pulse_clr();
    sel_small = 1'b1;
    for (int i = 0; i < 15; i++) send(hdr_word(5'd1), 1'b1);
    n_checks++;
    if (err_cnt_s !== 4'hF) begin
      n_fail++; $display("FAIL sat_reach: got %h want F", err_cnt_s);
    end
    send(hdr_word(5'd1), 1'b1);
    send(32'hB6CE8400, 1'b0);
    send(32'h01CACA05, 1'b1);
    n_checks++;
    if (err_cnt_s !== 4'hF || err_flags_s !== 5'b01001 || pkt_cnt_s !== 4'h0) begin
      n_fail++; $display("FAIL sat_hold: got err=%h flags=%b pkt=%h want F 01001 0", err_cnt_s, err_flags_s, pkt_cnt_s);
    end
    sel_small = 1'b0;
    n_checks++;
    if (err_cnt !== 16'd0) begin
      n_fail++; $display("FAIL sat_isolation: got %0d want 0", err_cnt);
    end
  endtask

`ifdef FMPS_CHECK_SEQ_EN
  task automatic test_sequence();
    pulse_clr();
    pulse_fa();
    send_pkt(5'd0, 8'h20);
    send_pkt(5'd1, 8'h20);
    send_pkt(5'd3, 8'h20);
    n_checks++;
    if (err_flags !== 5'b10000 || err_cnt !== 16'd1 || pkt_cnt !== 16'd2 || last_idx !== 5'd1) begin
      n_fail++; $display("FAIL seq_skip: got flags=%b err=%0d pkt=%0d idx=%0d want 10000 1 2 1", err_flags, err_cnt, pkt_cnt, last_idx);
    end
    pulse_fa();
    send_pkt(5'd7, 8'h20);
    n_checks++;
    if (err_cnt !== 16'd2 || pkt_cnt !== 16'd2) begin
      n_fail++; $display("FAIL seq_fa: got err=%0d pkt=%0d want 2 2", err_cnt, pkt_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_good_packets();
    test_bad_magic();
    test_bad_fields();
    test_header_tlast();
    test_drop_resync();
    test_fa_midpacket();
    test_clear_in_eval();
    test_reset_midpacket();
    test_saturation();
`ifdef FMPS_CHECK_SEQ_EN
    test_sequence();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
